// File: rtl/mult_div_unit_pkg.sv
// Shared types and defaults for the HI/LO multiply/divide unit.
// Op encodings match the E-stage decode of mult/multu/div/divu.
package mult_div_unit_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    localparam int unsigned MULT_CYC_DEF = 5;
    localparam int unsigned DIV_CYC_DEF  = 10;
    localparam int unsigned CNT_W        = 5;

    function automatic logic op_is_div(input md_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// E-stage request and HI/LO result bundle between the pipeline and the
// multiply/divide unit; master is the pipeline side.
interface mult_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hi_we;
    logic        lo_we;
    logic        busy;
    logic [4:0]  busyCnt;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, op, A, B, hi_we, lo_we,
        input  busy, busyCnt, HI, LO
    );

    modport slave (
        input  start, op, A, B, hi_we, lo_we,
        output busy, busyCnt, HI, LO
    );
endinterface

// File: rtl/mult_div_unit_md_core.sv
// Combinational datapath: 64-bit product or {remainder, quotient} of the
// latched operands, plus a divide-by-zero flag.
module mult_div_unit_md_core
    import mult_div_unit_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  md_op_e      op,
    output logic [63:0] result,
    output logic        div_by_zero
);
    logic        is_signed;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] divisor;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        is_signed = (op == MD_MULT) || (op == MD_DIV);

        // The low 64 bits of an extended product are correct for both signednesses
        ext_a   = {{32{is_signed & a[31]}}, a};
        ext_b   = {{32{is_signed & b[31]}}, b};
        product = ext_a * ext_b;

        // Signed divide runs on magnitudes; 0x80000000/-1 falls out as 0x80000000 r 0
        a_neg       = is_signed & a[31];
        b_neg       = is_signed & b[31];
        abs_a       = a_neg ? (~a + 32'd1) : a;
        abs_b       = b_neg ? (~b + 32'd1) : b;
        div_by_zero = op_is_div(op) && (b == '0);
        divisor     = (b == '0) ? 32'd1 : abs_b;
        uq          = abs_a / divisor;
        ur          = abs_a % divisor;
        quot        = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
        rem         = a_neg ? (~ur + 32'd1) : ur;

        result = op_is_div(op) ? {rem, quot} : product;
    end

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage HI/LO multiply/divide unit: latches operands on start, counts
// down a fixed latency, then commits {HI,LO}; also services mthi/mtlo.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned MULT_CYC = MULT_CYC_DEF,
    parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
    input  logic             clk,
    input  logic             reset,
    mult_div_unit_if.slave   bus
);
    md_state_e        state;
    md_state_e        state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    md_op_e           op_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic             latch;
    logic             commit;
    logic [63:0]      result;
    logic             div_by_zero;

    mult_div_unit_md_core u_core (
        .a           (a_q),
        .b           (b_q),
        .op          (op_q),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        latch   = 1'b0;
        commit  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    latch   = 1'b1;
                    cnt_n   = op_is_div(md_op_e'(bus.op)) ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
                    state_n = RUN;
                end
            end
            RUN: begin
                cnt_n = cnt - 5'd1;
                if (cnt == 5'd1) begin
                    commit  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= MD_MULT;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (latch) begin
                a_q  <= bus.A;
                b_q  <= bus.B;
                op_q <= md_op_e'(bus.op);
            end
            // mthi/mtlo only land while idle and not starting; start wins
            if (commit) begin
                if (!div_by_zero) begin
                    hi_q <= result[63:32];
                    lo_q <= result[31:0];
                end
            end else if (state == IDLE && !bus.start) begin
                if (bus.hi_we) hi_q <= bus.A;
                if (bus.lo_we) lo_q <= bus.A;
            end
        end
    end

    always_comb begin
        bus.busyCnt = cnt;
        bus.busy    = (cnt != '0);
        bus.HI      = hi_q;
        bus.LO      = lo_q;
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vectors with literal
// expectations plus a per-cycle reference model for two latency settings.
module tb_mult_div_unit;

    logic clk = 1'b0;
    logic reset;

    mult_div_unit_if bus ();
    mult_div_unit_if bus1 ();

    mult_div_unit #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mult_div_unit #(.MULT_CYC(1), .DIV_CYC(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    assign bus1.start = bus.start;
    assign bus1.op    = bus.op;
    assign bus1.A     = bus.A;
    assign bus1.B     = bus.B;
    assign bus1.hi_we = bus.hi_we;
    assign bus1.lo_we = bus.lo_we;

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int viol     = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference arithmetic: {div_by_zero, hi, lo}
    function automatic logic [64:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              sa;
        int              sb;
        sa = a;
        sb = b;
        case (op)
            2'b00: begin
                sp = longint'(sa) * longint'(sb);
                return {1'b0, 64'(sp)};
            end
            2'b01: begin
                up = {32'd0, a} * {32'd0, b};
                return {1'b0, up};
            end
            2'b10: begin
                if (b == 32'd0) return {1'b1, 64'd0};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
                return {1'b0, 32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'd0) return {1'b1, 64'd0};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    function automatic int unsigned lat(input int k, input logic [1:0] op);
        if (k == 0) return op[1] ? 10 : 5;
        return 1;
    endfunction

    // Model: an accepted op finishes lat() edges later; busyCnt is the distance to that edge
    int unsigned cyc;
    logic [31:0] m_hi[2];
    logic [31:0] m_lo[2];
    bit          pend[2];
    int unsigned done_at[2];
    logic [64:0] res[2];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc <= 0;
            for (int k = 0; k < 2; k++) begin
                m_hi[k]    <= '0;
                m_lo[k]    <= '0;
                pend[k]    <= 1'b0;
                done_at[k] <= 0;
                res[k]     <= '0;
            end
        end else begin
            cyc <= cyc + 1;
            for (int k = 0; k < 2; k++) begin
                if (pend[k]) begin
                    if (cyc + 1 == done_at[k]) begin
                        pend[k] <= 1'b0;
                        if (!res[k][64]) begin
                            m_hi[k] <= res[k][63:32];
                            m_lo[k] <= res[k][31:0];
                        end
                    end
                end else if (bus.start) begin
                    res[k]     <= ref_result(bus.op, bus.A, bus.B);
                    pend[k]    <= 1'b1;
                    done_at[k] <= cyc + 1 + lat(k, bus.op);
                end else begin
                    if (bus.hi_we) m_hi[k] <= bus.A;
                    if (bus.lo_we) m_lo[k] <= bus.A;
                end
            end
            if (pend[0] && (bus.start || bus.hi_we || bus.lo_we)) begin
                viol <= viol + 1;
                $display("NOTE: protocol violation at cycle %0d (HI/LO request while busy)", cyc + 1);
            end
        end
    end

    task automatic cmp_one(input int k, input logic [4:0] cnt, input logic bsy,
                           input logic [31:0] hi, input logic [31:0] lo);
        int unsigned exp_cnt;
        exp_cnt = pend[k] ? done_at[k] - cyc : 0;
        chk($sformatf("model%0d_busyCnt", k), 64'(cnt), 64'(exp_cnt));
        chk($sformatf("model%0d_busy", k), 64'(bsy), 64'(pend[k]));
        chk($sformatf("model%0d_HI", k), 64'(hi), 64'(m_hi[k]));
        chk($sformatf("model%0d_LO", k), 64'(lo), 64'(m_lo[k]));
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp_one(0, bus.busyCnt, bus.busy, bus.HI, bus.LO);
            cmp_one(1, bus1.busyCnt, bus1.busy, bus1.HI, bus1.LO);
        end
    end

    task automatic drive(input logic s, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic hw, input logic lw);
        bus.start = s;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        bus.hi_we = hw;
        bus.lo_we = lw;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 64) begin
            n++;
            idle();
        end
        chk("wait_idle_busy", 64'(bus.busy), 64'd0);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
        drive(1'b1, op, a, b, 1'b0, 1'b0);
        wait_idle();
        chk({name, "_HI"}, 64'(bus.HI), 64'(exp_hi));
        chk({name, "_LO"}, 64'(bus.LO), 64'(exp_lo));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.A     = '0;
        bus.B     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_HI", 64'(bus.HI), 64'd0);
        chk("reset_LO", 64'(bus.LO), 64'd0);
        chk("reset_busyCnt", 64'(bus.busyCnt), 64'd0);
        cmp_en = 1'b1;

        // mult -2 * 3 with exact countdown 5..1
        drive(1'b1, 2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        for (int i = 5; i >= 1; i--) begin
            chk($sformatf("mult_busyCnt_%0d", i), 64'(bus.busyCnt), 64'(i));
            idle();
        end
        chk("mult_done_busyCnt", 64'(bus.busyCnt), 64'd0);
        chk("mult_HI", 64'(bus.HI), 64'hFFFF_FFFF);
        chk("mult_LO", 64'(bus.LO), 64'hFFFF_FFFA);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
        run_op(2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, "mult_extreme");

        drive(1'b1, 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        chk("div_busyCnt_start", 64'(bus.busyCnt), 64'd10);
        wait_idle();
        chk("div_neg_HI", 64'(bus.HI), 64'hFFFF_FFFF);
        chk("div_neg_LO", 64'(bus.LO), 64'hFFFF_FFFD);

        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, "div_negdivisor");
        run_op(2'b11, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF, "divu");

        // Divide by zero preserves preloaded HI/LO after full latency
        drive(1'b0, 2'b00, 32'h11, 32'd0, 1'b1, 1'b0);
        drive(1'b0, 2'b00, 32'h22, 32'd0, 1'b0, 1'b1);
        chk("mthi_HI", 64'(bus.HI), 64'h11);
        chk("mtlo_LO", 64'(bus.LO), 64'h22);
        drive(1'b1, 2'b11, 32'd7, 32'd0, 1'b0, 1'b0);
        n = 0;
        while (bus.busy && n < 40) begin
            n++;
            idle();
        end
        chk("divz_busy_cycles", 64'(n), 64'd10);
        chk("divz_HI", 64'(bus.HI), 64'h11);
        chk("divz_LO", 64'(bus.LO), 64'h22);

        drive(1'b0, 2'b00, 32'h5A, 32'd0, 1'b1, 1'b1);
        chk("mt_both_HI", 64'(bus.HI), 64'h5A);
        chk("mt_both_LO", 64'(bus.LO), 64'h5A);

        // mtlo idle, then mthi during an in-flight div is dropped
        drive(1'b0, 2'b00, 32'h1234, 32'd0, 1'b0, 1'b1);
        chk("mtlo_idle_LO", 64'(bus.LO), 64'h1234);
        drive(1'b1, 2'b10, 32'd100, 32'd7, 1'b0, 1'b0);
        drive(1'b0, 2'b00, 32'hDEAD, 32'd0, 1'b1, 1'b0);
        wait_idle();
        chk("div_inflight_HI", 64'(bus.HI), 64'd2);
        chk("div_inflight_LO", 64'(bus.LO), 64'd14);

        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, "div_ovf");

        // start together with mthi/mtlo: the write is dropped
        drive(1'b1, 2'b00, 32'd2, 32'd3, 1'b1, 1'b1);
        chk("start_we_HI_kept", 64'(bus.HI), 64'd0);
        chk("start_we_LO_kept", 64'(bus.LO), 64'h8000_0000);
        wait_idle();
        chk("start_we_HI", 64'(bus.HI), 64'd0);
        chk("start_we_LO", 64'(bus.LO), 64'd6);

        // Reset in the middle of a div
        drive(1'b1, 2'b10, 32'd50, 32'd3, 1'b0, 1'b0);
        repeat (3) idle();
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midreset_busyCnt", 64'(bus.busyCnt), 64'd0);
        chk("midreset_busy", 64'(bus.busy), 64'd0);
        chk("midreset_HI", 64'(bus.HI), 64'd0);
        chk("midreset_LO", 64'(bus.LO), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        run_op(2'b00, 32'd3, 32'd4, 32'd0, 32'd12, "post_reset_mult");

        repeat (2) idle();
        chk("protocol_violations", 64'(viol), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Execute-stage HI/LO multiply/divide unit for the 5-stage pipeline.
- Accepts mult/multu/div/divu from E, runs a fixed-latency countdown, then commits the 64-bit result to HI/LO.
- Accepts mthi/mtlo writes and exports `start` and `busyCnt` to the hazard unit, which stalls D-stage HI/LO instructions while `start || busyCnt > 1`.

Parameters:
- MULT_CYC, 5: busy cycles for mult/multu after the start cycle (1..31).
- DIV_CYC, 10: busy cycles for div/divu after the start cycle (1..31).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  E-stage instruction is mult/multu/div/divu this cycle.
- op  in  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start.
- A  in  32  rs operand, already forwarded; also mthi/mtlo data.
- B  in  32  rt operand, already forwarded.
- hi_we  in  1  mthi: write A into HI.
- lo_we  in  1  mtlo: write A into LO.
- busy  out  1  high while busyCnt != 0.
- busyCnt  out  5  remaining busy cycles.
- HI  out  32  HI register.
- LO  out  32  LO register.

Behaviour:
- Reset (async, active-high): HI=0, LO=0, busyCnt=0, busy=0, FSM=IDLE, operand/op latches=0. Reset mid-operation aborts the computation and HI/LO stay 0.
- FSM states: IDLE and RUN.
- IDLE with start=1:
  - latch A, B and op;
  - next busyCnt = MULT_CYC (op[1]=0) or DIV_CYC (op[1]=1);
  - go to RUN.
- RUN:
  - each cycle busyCnt decrements by 1;
  - in the cycle where busyCnt==1, HI/LO are written at that clock edge, busyCnt goes to 0, FSM returns to IDLE.
- Latency example, mult started in cycle 0:
  - busyCnt is 5,4,3,2,1 in cycles 1..5;
  - HI/LO are valid from cycle 6;
  - a dependent mfhi in D is released in cycle 5 (busyCnt==1) and reads the new HI in E in cycle 6.
- Arithmetic on latched operands:
  - mult: {HI,LO} = $signed(A)*$signed(B), 64-bit.
  - multu: unsigned 64-bit product.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the dividend's sign.
  - divu: unsigned quotient/remainder.
- Divide by zero: full DIV_CYC latency still runs; HI and LO are left unchanged.
- Signed overflow 0x80000000 / -1: LO=0x80000000, HI=0.
- mthi/mtlo:
  - in IDLE with start=0, hi_we/lo_we write A at the clock edge, with no latency;
  - both asserted writes A to both registers.
- start while in RUN: ignored, the current operation continues. The hazard unit prevents this; the bench flags it as an assertion.
- hi_we/lo_we while in RUN: ignored (same assertion).
- start and hi_we/lo_we in the same cycle: start wins and the write is dropped.
- Parameter value 1: busyCnt goes 1, then 0, and the result is written one edge after start.
- Outputs are registers only; no combinational path from inputs to HI/LO/busyCnt. `busy` is decoded from busyCnt.

Decomposition:
- Op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU) and the default latencies belong in the shared macro.v header, alongside the instruction-bus bit indices.
- One combinational sub-module, md_core, is natural: it takes the latched A, B and op and returns the 64-bit {hi,lo} result plus a div_by_zero flag.
- The FSM, counter and registers stay in mult_div_unit.

Test Plan:
- mult A=0xFFFFFFFE (-2), B=3, start in cycle 0 -> busyCnt 5,4,3,2,1, then 0; HI=0xFFFFFFFF, LO=0xFFFFFFFA from cycle 6.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001.
- div A=-7 (0xFFFFFFF9), B=2 -> busyCnt counts 10..1; LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- divu A=7, B=0 with HI=0x11, LO=0x22 preloaded via mthi/mtlo -> busy for 10 cycles; HI/LO remain 0x11/0x22.
- mtlo A=0x1234 while idle -> LO=0x1234 next edge. Then mthi during an in-flight div -> ignored and assertion fires; the div result still commits.
- Start div, assert reset in cycle 4 -> immediately busyCnt=0, busy=0, HI=LO=0; a new mult started after reset release completes normally.
